io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
- CPU-side master for the stack core's I/O bus.
- Turns single-instruction io_rd/io_wr requests from the execute stage into req/ack bus transactions to peripherals.
- Stalls the core until each transaction completes.
- Drives io_din, the I/O read operand that the core's operand selector consumes.

Parameters:
WIDTH, 32, data width of core and bus.
ADDR_WIDTH, 16, I/O address width.
TIMEOUT, 255, max cycles waiting for ack before abort; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge.
resetq  in  1  asynchronous active-low reset.
io_rd  in  1  core requests I/O read this cycle; held while io_stall=1.
io_wr  in  1  core requests I/O write this cycle; held while io_stall=1.
io_addr  in  ADDR_WIDTH  I/O address from core.
io_dout  in  WIDTH  write data from core.
io_din  out  WIDTH  read data to core operand selector.
io_stall  out  1  holds core pipeline.
io_err  out  1  one-cycle pulse on bus error, timeout, or rd+wr conflict.
bus_req  out  1  transaction request.
bus_we  out  1  1=write, 0=read; valid while bus_req.
bus_addr  out  ADDR_WIDTH  registered address; valid while bus_req.
bus_wdata  out  WIDTH  registered write data; valid while bus_req.
bus_rdata  in  WIDTH  read data from peripheral; sampled on bus_ack.
bus_ack  in  1  transaction complete.
bus_err  in  1  transaction failed; completes transaction.

Behaviour:
- Reset values (async, while resetq=0): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, timeout counter=0, io_err=0. Reset mid-transaction drops bus_req immediately; the transaction is abandoned.
- States: IDLE, REQ.
- IDLE behaviour:
  - If io_rd|io_wr: io_stall=1 combinationally in the same cycle.
  - On the clock edge: capture io_addr, io_dout and we=io_wr; clear counter; go to REQ.
  - If both io_rd and io_wr: the write is performed, the read is dropped, and io_err pulses in the capture cycle.
  - bus_ack/bus_err seen in IDLE are ignored.
- REQ behaviour:
  - bus_req=1; bus_we, bus_addr and bus_wdata held stable.
  - done = bus_ack | bus_err | (TIMEOUT!=0 & counter==TIMEOUT).
  - io_stall = ~done.
  - Counter increments each REQ cycle without done; it saturates and does not wrap.
- Completion (cycle where done=1, state REQ): core consumes the result in this cycle; next state IDLE; bus_req deasserts next cycle.
  - Read with bus_ack and not bus_err: io_din = bus_rdata (combinational bypass); rdata_q <= bus_rdata.
  - bus_err or timeout: io_err=1 for this cycle; for a read, io_din = all ones and rdata_q <= all ones.
  - bus_ack together with bus_err: treated as error.
  - Write completion leaves rdata_q unchanged.
- io_din when not completing a read: rdata_q, i.e. the last read result, held until the next read completes.
- Latency:
  - Minimum 2 cycles per access: request cycle, then bus_req cycle with ack. io_stall is high only in the request cycle.
  - Ack after k cycles of bus_req gives k+1 stall cycles.
- Back-to-back: a new io_rd/io_wr in the cycle after completion (state IDLE) starts a new transaction immediately. There is no idle bus cycle beyond the one bus_req=0 cycle.
- Timeout: with TIMEOUT=N, abort occurs in the (N+1)th cycle of bus_req when no ack has arrived.

Test Plan:
1. Read, zero-wait: io_rd=1, io_addr=16'h0010; bus_ack=1 in first bus_req cycle with bus_rdata=32'hDEADBEEF.
   -> bus_req high exactly 1 cycle, bus_we=0, bus_addr=0010; io_stall high 1 cycle; io_din=DEADBEEF in ack cycle and held afterwards; io_err never set.
2. Write, 3 wait states: io_wr=1, io_addr=16'h0004, io_dout=32'h12345678; ack on 4th bus_req cycle.
   -> bus_we=1, addr/data stable all 4 cycles; io_stall high 4 cycles; io_din keeps prior value.
3. Timeout: TIMEOUT=5, io_rd, never ack.
   -> bus_req high 6 cycles then low; io_err pulse in the 6th cycle; io_din=FFFFFFFF; state returns to IDLE and the next read succeeds normally.
4. Error: read with bus_ack=1 and bus_err=1 same cycle.
   -> io_err pulse; io_din=FFFFFFFF. Conflict case io_rd=io_wr=1 -> write issued (bus_we=1), io_err pulses in the request cycle.
5. Reset mid-transaction: resetq=0 during the 2nd wait cycle of a read.
   -> bus_req drops without a clock edge; io_din=0, io_stall=0 after release; spurious bus_ack arriving after release is ignored.
6. Back-to-back read, write, read, each zero-wait.
   -> three transactions in 6 cycles; io_din updates only on the read completions.

Source files
------------

// File: rtl/io_bus_master.sv
// CPU-side I/O bus master: turns single-cycle io_rd/io_wr requests into
// req/ack bus transactions, stalls the core meanwhile and returns read data.
module io_bus_master #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  io_rd,
  input  logic                  io_wr,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [WIDTH-1:0]      io_dout,
  output logic [WIDTH-1:0]      io_din,
  output logic                  io_stall,
  output logic                  io_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0]      bus_wdata,
  input  logic [WIDTH-1:0]      bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  logic             done;
  logic             fail;

  assign timed_out = (TIMEOUT != 0) && (cnt == TMO);
  assign done      = (state == REQ) && (bus_ack || bus_err || timed_out);
  // An ack landing in the timeout cycle still counts as a clean completion.
  assign fail      = done && (bus_err || (timed_out && !bus_ack));

  always_comb begin
    io_stall = 1'b0;
    io_err   = 1'b0;
    io_din   = rdata_q;
    if (state == IDLE) begin
      io_stall = io_rd | io_wr;
      io_err   = io_rd & io_wr;
    end else begin
      io_stall = ~done;
      io_err   = fail;
      if (done && !bus_we) io_din = fail ? '1 : bus_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_rd || io_wr) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= io_wr;
            bus_addr  <= io_addr;
            bus_wdata <= io_dout;
            cnt       <= '0;
          end
        end
        REQ: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            if (!bus_we) rdata_q <= fail ? '1 : bus_rdata;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: reads, writes, wait states, timeout,
// bus error, rd/wr conflict, async reset mid-transaction and back-to-back use.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_rd, io_wr;
  logic [15:0] io_addr;
  logic [31:0] io_dout;
  logic [31:0] io_din;
  logic        io_stall, io_err;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;

  int vectors = 0;
  int errs    = 0;

  io_bus_master #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(5)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .io_stall(io_stall), .io_err(io_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_in();
    io_rd = 1'b0; io_wr = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    bus_rdata = 32'h0;
  endtask

  initial begin
    resetq = 1'b0; io_addr = 16'h0; io_dout = 32'h0;
    idle_in();
    repeat (2) tick();
    settle();
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chkw("rst_bus_addr", 32'(bus_addr), 32'h0);
    chkw("rst_io_din", io_din, 32'h0);
    chk1("rst_io_stall", io_stall, 1'b0);
    chk1("rst_io_err", io_err, 1'b0);
    tick();
    resetq = 1'b1;
    tick();

    // 1: zero-wait read
    io_rd = 1'b1; io_addr = 16'h0010;
    settle();
    chk1("t1_req_stall", io_stall, 1'b1);
    chk1("t1_req_busreq", bus_req, 1'b0);
    chk1("t1_req_err", io_err, 1'b0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    settle();
    chk1("t1_busreq", bus_req, 1'b1);
    chk1("t1_we", bus_we, 1'b0);
    chkw("t1_addr", 32'(bus_addr), 32'h0010);
    chk1("t1_stall", io_stall, 1'b0);
    chkw("t1_din", io_din, 32'hDEADBEEF);
    chk1("t1_err", io_err, 1'b0);
    tick();
    idle_in();
    settle();
    chk1("t1_after_busreq", bus_req, 1'b0);
    chkw("t1_after_din", io_din, 32'hDEADBEEF);
    chk1("t1_after_stall", io_stall, 1'b0);
    tick();

    // 2: write with 3 wait states
    io_wr = 1'b1; io_addr = 16'h0004; io_dout = 32'h12345678;
    settle();
    chk1("t2_req_stall", io_stall, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk1("t2_wait_busreq", bus_req, 1'b1);
      chk1("t2_wait_we", bus_we, 1'b1);
      chkw("t2_wait_addr", 32'(bus_addr), 32'h0004);
      chkw("t2_wait_wdata", bus_wdata, 32'h12345678);
      chk1("t2_wait_stall", io_stall, 1'b1);
      chkw("t2_wait_din", io_din, 32'hDEADBEEF);
      tick();
    end
    bus_ack = 1'b1;
    settle();
    chk1("t2_ack_we", bus_we, 1'b1);
    chkw("t2_ack_wdata", bus_wdata, 32'h12345678);
    chk1("t2_ack_stall", io_stall, 1'b0);
    chk1("t2_ack_err", io_err, 1'b0);
    chkw("t2_ack_din", io_din, 32'hDEADBEEF);
    tick();
    idle_in();
    settle();
    chk1("t2_after_busreq", bus_req, 1'b0);
    chkw("t2_after_din", io_din, 32'hDEADBEEF);
    tick();

    // 3: timeout after 6 bus_req cycles, then a normal read
    io_rd = 1'b1; io_addr = 16'h0020;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk1("t3_wait_busreq", bus_req, 1'b1);
      chk1("t3_wait_stall", io_stall, 1'b1);
      chk1("t3_wait_err", io_err, 1'b0);
      tick();
    end
    settle();
    chk1("t3_to_busreq", bus_req, 1'b1);
    chk1("t3_to_stall", io_stall, 1'b0);
    chk1("t3_to_err", io_err, 1'b1);
    chkw("t3_to_din", io_din, 32'hFFFFFFFF);
    tick();
    idle_in();
    settle();
    chk1("t3_after_busreq", bus_req, 1'b0);
    chk1("t3_after_err", io_err, 1'b0);
    chkw("t3_after_din", io_din, 32'hFFFFFFFF);
    tick();
    io_rd = 1'b1; io_addr = 16'h0030;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h000000A5;
    settle();
    chkw("t3_next_addr", 32'(bus_addr), 32'h0030);
    chkw("t3_next_din", io_din, 32'h000000A5);
    chk1("t3_next_err", io_err, 1'b0);
    tick();
    idle_in();
    settle();
    chkw("t3_next_hold", io_din, 32'h000000A5);
    tick();

    // 4: ack+err on a read, then rd/wr conflict
    io_rd = 1'b1; io_addr = 16'h0040;
    tick();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h00001234;
    settle();
    chk1("t4_err", io_err, 1'b1);
    chkw("t4_din", io_din, 32'hFFFFFFFF);
    chk1("t4_stall", io_stall, 1'b0);
    tick();
    idle_in();
    settle();
    chk1("t4_after_err", io_err, 1'b0);
    chkw("t4_after_din", io_din, 32'hFFFFFFFF);
    tick();
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 16'h0050; io_dout = 32'hCAFEF00D;
    settle();
    chk1("t4c_req_err", io_err, 1'b1);
    chk1("t4c_req_stall", io_stall, 1'b1);
    tick();
    settle();
    chk1("t4c_we", bus_we, 1'b1);
    chkw("t4c_wdata", bus_wdata, 32'hCAFEF00D);
    chk1("t4c_wait_err", io_err, 1'b0);
    chk1("t4c_wait_stall", io_stall, 1'b1);
    tick();
    bus_ack = 1'b1;
    settle();
    chk1("t4c_ack_err", io_err, 1'b0);
    chk1("t4c_ack_stall", io_stall, 1'b0);
    chkw("t4c_ack_din", io_din, 32'hFFFFFFFF);
    tick();
    idle_in();
    tick();

    // 5: async reset during the second wait cycle of a read
    io_rd = 1'b1; io_addr = 16'h0060;
    tick();
    tick();
    settle();
    chk1("t5_pre_busreq", bus_req, 1'b1);
    #1 resetq = 1'b0;
    #1;
    chk1("t5_rst_busreq", bus_req, 1'b0);
    chkw("t5_rst_din", io_din, 32'h0);
    tick();
    idle_in();
    tick();
    resetq = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    settle();
    chk1("t5_rel_busreq", bus_req, 1'b0);
    chk1("t5_rel_stall", io_stall, 1'b0);
    chkw("t5_rel_din", io_din, 32'h0);
    chk1("t5_rel_err", io_err, 1'b0);
    tick();
    settle();
    chk1("t5_spur_busreq", bus_req, 1'b0);
    chkw("t5_spur_din", io_din, 32'h0);
    tick();
    idle_in();
    tick();

    // 6: back-to-back read, write, read
    io_rd = 1'b1; io_addr = 16'h0070;
    settle();
    chk1("t6_c0_stall", io_stall, 1'b1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    settle();
    chkw("t6_c1_din", io_din, 32'h11111111);
    chk1("t6_c1_stall", io_stall, 1'b0);
    tick();
    io_rd = 1'b0; io_wr = 1'b1; io_addr = 16'h0074; io_dout = 32'hAAAA5555;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk1("t6_c2_busreq", bus_req, 1'b0);
    chk1("t6_c2_stall", io_stall, 1'b1);
    chkw("t6_c2_din", io_din, 32'h11111111);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h99999999;
    settle();
    chk1("t6_c3_we", bus_we, 1'b1);
    chkw("t6_c3_addr", 32'(bus_addr), 32'h0074);
    chkw("t6_c3_din", io_din, 32'h11111111);
    tick();
    io_wr = 1'b0; io_rd = 1'b1; io_addr = 16'h0078;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    settle();
    chk1("t6_c4_busreq", bus_req, 1'b0);
    chkw("t6_c4_din", io_din, 32'h11111111);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h22222222;
    settle();
    chk1("t6_c5_we", bus_we, 1'b0);
    chkw("t6_c5_din", io_din, 32'h22222222);
    tick();
    idle_in();
    settle();
    chk1("t6_c6_busreq", bus_req, 1'b0);
    chkw("t6_c6_din", io_din, 32'h22222222);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
